// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// change_dispenser
// Pays a 4-bit change amount out as single-cycle coin pulses, largest
// denomination first, drawing on a per-denomination coin stock. When the
// stock cannot cover the amount, the unpaid remainder is reported on
// shortfall together with the done pulse.
//
// Handshake: start is a level request that is only sampled while busy is
// low (IDLE). Once accepted, busy stays high until the cycle after done,
// and any start or refill seen in the meantime is dropped, not queued.
// The upstream stage must hold its next start until busy is low.
module change_dispenser #(
    parameter int VAL_A      = 5,
    parameter int VAL_B      = 2,
    parameter int VAL_C      = 1,
    parameter int STOCK_MAX  = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] change_in,
    input  logic       refill,
    output logic       busy,
    output logic       coin_a,
    output logic       coin_b,
    output logic       coin_c,
    output logic       done,
    output logic       short,
    output logic [3:0] shortfall,
    output logic [3:0] stock_a,
    output logic [3:0] stock_b,
    output logic [3:0] stock_c,
    output logic [2:0] state_dbg
);

    // Coin values and stock limit narrowed to the datapath width.
    localparam logic [3:0]  V_A        = 4'(VAL_A);
    localparam logic [3:0]  V_B        = 4'(VAL_B);
    localparam logic [3:0]  V_C        = 4'(VAL_C);
    localparam logic [3:0]  STOCK_FULL = 4'(STOCK_MAX);
    // The gap counter counts 0 .. GAP_CYCLES-1 before returning to SELECT.
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2,
        SEL_C    = 2'd3
    } sel_t;

    state_t      state;
    sel_t        sel;
    sel_t        pick;
    logic [3:0]  rem;
    logic [3:0]  sel_val;
    logic [15:0] gap_cnt;
    logic        can_a;
    logic        can_b;
    logic        can_c;

    assign state_dbg = state;

    // Largest coin that both fits in the remaining amount and is in stock.
    always_comb begin
        can_a = (stock_a != 4'd0) && (rem >= V_A);
        can_b = (stock_b != 4'd0) && (rem >= V_B);
        can_c = (stock_c != 4'd0) && (rem >= V_C);
        if (can_a) begin
            pick = SEL_A;
        end else if (can_b) begin
            pick = SEL_B;
        end else if (can_c) begin
            pick = SEL_C;
        end else begin
            pick = SEL_NONE;
        end
    end

    // Value of the coin latched for the current pulse.
    always_comb begin
        sel_val = 4'd0;
        case (sel)
            SEL_A:   sel_val = V_A;
            SEL_B:   sel_val = V_B;
            SEL_C:   sel_val = V_C;
            default: sel_val = 4'd0;
        endcase
    end

    // Payout FSM with registered outputs. Coin, done and short are
    // single-cycle pulses, so they default low every cycle and are set
    // only on the edge that enters PULSE or DONE. A reset mid-pulse drops
    // the coin immediately; the stock decrement happens on PULSE exit and
    // therefore never occurs for a truncated pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= SEL_NONE;
            rem       <= 4'd0;
            gap_cnt   <= 16'd0;
            shortfall <= 4'd0;
            stock_a   <= STOCK_FULL;
            stock_b   <= STOCK_FULL;
            stock_c   <= STOCK_FULL;
            busy      <= 1'b0;
            coin_a    <= 1'b0;
            coin_b    <= 1'b0;
            coin_c    <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
        end else begin
            coin_a <= 1'b0;
            coin_b <= 1'b0;
            coin_c <= 1'b0;
            done   <= 1'b0;
            short  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Refill and start may coincide; SELECT then sees the
                    // refilled stock one cycle later.
                    if (refill) begin
                        stock_a <= STOCK_FULL;
                        stock_b <= STOCK_FULL;
                        stock_c <= STOCK_FULL;
                    end
                    if (start) begin
                        rem       <= change_in;
                        shortfall <= 4'd0;
                        busy      <= 1'b1;
                        state     <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    if (rem == 4'd0) begin
                        // Fully paid: shortfall was cleared at start.
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (pick != SEL_NONE) begin
                        sel    <= pick;
                        coin_a <= (pick == SEL_A);
                        coin_b <= (pick == SEL_B);
                        coin_c <= (pick == SEL_C);
                        state  <= ST_PULSE;
                    end else begin
                        // Nothing usable left; rem is non-zero here.
                        shortfall <= rem;
                        short     <= 1'b1;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end

                ST_PULSE: begin
                    // The selected coin fit in rem and was in stock, so
                    // neither subtraction can wrap.
                    rem <= rem - sel_val;
                    case (sel)
                        SEL_A:   stock_a <= stock_a - 4'd1;
                        SEL_B:   stock_b <= stock_b - 4'd1;
                        SEL_C:   stock_c <= stock_c - 4'd1;
                        default: ;
                    endcase
                    gap_cnt <= 16'd0;
                    state   <= ST_GAP;
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
// Directed bench for change_dispenser: one instance with default
// parameters and one with STOCK_MAX = 2 for the exhaustion scenario.
module tb_change_dispenser;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (defaults) ----------------
    logic       start1 = 1'b0, refill1 = 1'b0;
    logic [3:0] change1 = 4'd0;
    logic       busy1, coin_a1, coin_b1, coin_c1, done1, short1;
    logic [3:0] shortfall1, stock_a1, stock_b1, stock_c1;
    logic [2:0] state1;

    change_dispenser dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .change_in(change1),
        .refill(refill1), .busy(busy1), .coin_a(coin_a1), .coin_b(coin_b1),
        .coin_c(coin_c1), .done(done1), .short(short1),
        .shortfall(shortfall1), .stock_a(stock_a1), .stock_b(stock_b1),
        .stock_c(stock_c1), .state_dbg(state1)
    );

    // ---------------- DUT 2 (STOCK_MAX = 2) ----------------
    logic       start2 = 1'b0, refill2 = 1'b0;
    logic [3:0] change2 = 4'd0;
    logic       busy2, coin_a2, coin_b2, coin_c2, done2, short2;
    logic [3:0] shortfall2, stock_a2, stock_b2, stock_c2;
    logic [2:0] state2;

    change_dispenser #(.STOCK_MAX(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .change_in(change2),
        .refill(refill2), .busy(busy2), .coin_a(coin_a2), .coin_b(coin_b2),
        .coin_c(coin_c2), .done(done2), .short(short2),
        .shortfall(shortfall2), .stock_a(stock_a2), .stock_b(stock_b2),
        .stock_c(stock_c2), .state_dbg(state2)
    );

    // ---------------- monitor mux ----------------
    int         mon_sel = 0;
    logic [2:0] m_coin;
    logic       m_done, m_busy, m_short;
    logic [3:0] m_sf;
    always_comb begin
        m_coin = {coin_a1, coin_b1, coin_c1};
        m_done = done1;
        m_busy = busy1;
        m_short = short1;
        m_sf = shortfall1;
        if (mon_sel != 0) begin
            m_coin = {coin_a2, coin_b2, coin_c2};
            m_done = done2;
            m_busy = busy2;
            m_short = short2;
            m_sf = shortfall2;
        end
    end

    // ---------------- scoreboard ----------------
    // Coin events: {edge[7:0], coin id[1:0]} with a=1, b=2, c=3.
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_coin(input int edge_n, input logic [1:0] id);
        exp_q.push_back({8'(edge_n), id});
    endtask

    task automatic check_stocks(input int which, input string tag,
                                input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec);
        if (which == 0) begin
            check({tag, ".stock_a"}, 32'(stock_a1), 32'(ea));
            check({tag, ".stock_b"}, 32'(stock_b1), 32'(eb));
            check({tag, ".stock_c"}, 32'(stock_c1), 32'(ec));
        end else begin
            check({tag, ".stock_a"}, 32'(stock_a2), 32'(ea));
            check({tag, ".stock_b"}, 32'(stock_b2), 32'(eb));
            check({tag, ".stock_c"}, 32'(stock_c2), 32'(ec));
        end
    endtask

    // Drives one payout, watches a fixed 40-cycle window and compares coin
    // events, done timing/count, short/shortfall and busy against the
    // expectations. poke_cyc > 0 pulses start (change 3) at that edge on
    // DUT 1 while it is busy.
    task automatic payout(input int which, input logic [3:0] amt, input logic with_refill,
                          input int poke_cyc, input int exp_done_edge,
                          input logic exp_short, input logic [3:0] exp_sf, input string tag);
        int done_cnt = 0;
        int done_edge = -1;
        int multi = 0;
        logic got_short = 1'b0;
        logic [3:0] got_sf = 4'd0;
        logic busy_after = 1'b1;
        logic [9:0] e, o;
        mon_sel = which;
        obs_q.delete();
        if (which == 0) begin
            change1 = amt; start1 = 1'b1; refill1 = with_refill;
        end else begin
            change2 = amt; start2 = 1'b1; refill2 = with_refill;
        end
        tick();  // edge 0
        start1 = 1'b0; refill1 = 1'b0; start2 = 1'b0; refill2 = 1'b0;
        check({tag, ".busy_rise"}, 32'(m_busy), 32'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == poke_cyc) begin
                change1 = 4'd3; start1 = 1'b1;
            end
            tick();  // now in the cycle after edge cyc
            start1 = 1'b0;
            if ((32'(m_coin[2]) + 32'(m_coin[1]) + 32'(m_coin[0])) > 1) multi++;
            if (m_coin[2]) obs_q.push_back({8'(cyc), 2'd1});
            if (m_coin[1]) obs_q.push_back({8'(cyc), 2'd2});
            if (m_coin[0]) obs_q.push_back({8'(cyc), 2'd3});
            if (m_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_edge = cyc;
                    got_short = m_short;
                    got_sf = m_sf;
                end
            end
            if (cyc == exp_done_edge + 1) busy_after = m_busy;
        end
        check({tag, ".done_count"}, 32'(done_cnt), 32'd1);
        check({tag, ".done_edge"}, 32'(done_edge), 32'(exp_done_edge));
        check({tag, ".short"}, 32'(got_short), 32'(exp_short));
        check({tag, ".shortfall"}, 32'(got_sf), 32'(exp_sf));
        check({tag, ".busy_fall"}, 32'(busy_after), 32'd0);
        check({tag, ".onehot"}, 32'(multi), 32'd0);
        check({tag, ".coin_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3ff;
            check({tag, ".coin_event"}, 32'(o), 32'(e));
        end
        obs_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int never_done;
        change1 = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("reset.busy", 32'(busy1), 32'd0);
        check("reset.done", 32'(done1), 32'd0);
        check("reset.coins", 32'({coin_a1, coin_b1, coin_c1}), 32'd0);
        check("reset.short", 32'(short1), 32'd0);
        check("reset.shortfall", 32'(shortfall1), 32'd0);
        check("reset.state", 32'(state1), 32'd0);
        check("reset.state2", 32'(state2), 32'd0);
        check_stocks(0, "reset1", 4'd8, 4'd8, 4'd8);
        check_stocks(1, "reset2", 4'd2, 4'd2, 4'd2);

        // Full stock, 8 units -> 5 + 2 + 1
        expect_coin(1, 2'd1); expect_coin(4, 2'd2); expect_coin(7, 2'd3);
        payout(0, 4'd8, 1'b0, 0, 10, 1'b0, 4'd0, "full8");
        check_stocks(0, "full8", 4'd7, 4'd7, 4'd7);

        // Zero change
        payout(0, 4'd0, 1'b0, 0, 1, 1'b0, 4'd0, "zero");
        check_stocks(0, "zero", 4'd7, 4'd7, 4'd7);

        // Exhaustion on the STOCK_MAX = 2 instance
        expect_coin(1, 2'd1); expect_coin(4, 2'd1); expect_coin(7, 2'd2);
        expect_coin(10, 2'd2); expect_coin(13, 2'd3);
        payout(1, 4'd15, 1'b0, 0, 16, 1'b0, 4'd0, "exh1");
        check_stocks(1, "exh1", 4'd0, 4'd0, 4'd1);

        expect_coin(1, 2'd3);
        payout(1, 4'd15, 1'b0, 0, 4, 1'b1, 4'd14, "exh2");
        check_stocks(1, "exh2", 4'd0, 4'd0, 4'd0);

        refill2 = 1'b1;
        tick();
        refill2 = 1'b0;
        tick();
        check_stocks(1, "refill2", 4'd2, 4'd2, 4'd2);
        check("refill2.shortfall_held", 32'(shortfall2), 32'd14);
        check("refill2.busy", 32'(busy2), 32'd0);

        // Start while busy is ignored
        expect_coin(1, 2'd1); expect_coin(4, 2'd2); expect_coin(7, 2'd3);
        payout(0, 4'd8, 1'b0, 5, 10, 1'b0, 4'd0, "busy_start");
        check_stocks(0, "busy_start", 4'd6, 4'd6, 4'd6);

        // Drain the large coin
        for (int i = 0; i < 6; i++) begin
            expect_coin(1, 2'd1);
            payout(0, 4'd5, 1'b0, 0, 4, 1'b0, 4'd0, "drain_a");
        end
        check_stocks(0, "drained", 4'd0, 4'd6, 4'd6);

        // No large coin left: 5 paid as 2 + 2 + 1
        expect_coin(1, 2'd2); expect_coin(4, 2'd2); expect_coin(7, 2'd3);
        payout(0, 4'd5, 1'b0, 0, 10, 1'b0, 4'd0, "no_a");
        check_stocks(0, "no_a", 4'd0, 4'd4, 4'd5);

        // Refill and start in the same cycle
        expect_coin(1, 2'd1);
        payout(0, 4'd5, 1'b1, 0, 4, 1'b0, 4'd0, "refill_start");
        check_stocks(0, "refill_start", 4'd7, 4'd8, 4'd8);

        // Reset while coin_a is high
        change1 = 4'd8; start1 = 1'b1;
        tick();  // edge 0
        start1 = 1'b0;
        tick();  // cycle after edge 1
        check("rst_mid.coin_a_pre", 32'(coin_a1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.coin_a", 32'(coin_a1), 32'd0);
        check("rst_mid.busy", 32'(busy1), 32'd0);
        check_stocks(0, "rst_mid", 4'd8, 4'd8, 4'd8);
        tick();
        rst_n = 1'b1;
        never_done = 0;
        repeat (6) begin
            tick();
            if (done1) never_done++;
        end
        check("rst_mid.no_done", 32'(never_done), 32'd0);
        check("rst_mid.idle", 32'(state1), 32'd0);
        check("rst_mid.busy_after", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the `customer` purchase block. It takes the 4-bit change amount that `customer` produces on `remainig_money` and pays it out as single-cycle coin pulses, one coin at a time and largest denomination first. It keeps a per-denomination coin stock that is depleted on each payout and refilled on request. When stock cannot cover the amount, it reports the unpaid remainder.

## Interface
Parameters:
- `VAL_A`, default 5: value of the large coin.
- `VAL_B`, default 2: value of the medium coin.
- `VAL_C`, default 1: value of the small coin. Constraint: `VAL_A > VAL_B > VAL_C >= 1`, all at most 15.
- `STOCK_MAX`, default 8: coins per denomination after reset or refill. Range 1..15.
- `GAP_CYCLES`, default 1: idle cycles after each coin pulse. Minimum 1.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a payout of `change_in`. Sampled only in IDLE.
- `change_in`, in, 4: amount to pay. Driven from `customer.remainig_money`.
- `refill`, in, 1: reload all stocks to `STOCK_MAX`. Sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `coin_a`, `coin_b`, `coin_c`, out, 1 each: one-cycle eject pulse for the matching coin.
- `done`, out, 1: one-cycle pulse marking the end of a payout.
- `short`, out, 1: high with `done` when `shortfall != 0`.
- `shortfall`, out, 4: unpaid remainder. Valid from `done` until the next accepted `start`.
- `stock_a`, `stock_b`, `stock_c`, out, 4 each: current coin counts.

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE. All outputs are a Moore decode of the state and data registers.
- **IDLE**
  - If `refill` is high, all stocks load `STOCK_MAX`.
  - If `start` is high, `rem <= change_in`, `shortfall <= 0`, and the state goes to SELECT.
  - If both are high in the same cycle, both take effect; the payout uses the refilled stock.
- **SELECT** picks the largest coin with value `<= rem` and stock `> 0`, and latches it as `sel`.
  - If a coin is found, go to PULSE.
  - If `rem == 0`, go to DONE.
  - If no coin is usable, latch `shortfall <= rem` and go to DONE.
- **PULSE**
  - The `coin_*` output for `sel` is high for exactly this one cycle.
  - On exit: `rem <= rem - value(sel)` and `stock_sel <= stock_sel - 1`.
  - Next state is GAP.
- **GAP**: all coin outputs are low. A counter runs `GAP_CYCLES` cycles, then the state returns to SELECT.
- **DONE**: `done` is high for one cycle, `short` equals `(shortfall != 0)`, and the state returns to IDLE.
- `start` and `refill` are ignored outside IDLE. They are level-sampled, not queued.
- Arithmetic and widths:
  - `rem` is 4 bits and cannot underflow, because a coin is selected only when its value is `<= rem`.
  - Stocks are 4 bits and are never decremented at 0.
- At most one `coin_*` output is high in any cycle.
- Reset, asynchronous and effective immediately, including mid-pulse:
  - state = IDLE, `rem` = 0, `shortfall` = 0.
  - All stocks = `STOCK_MAX`.
  - `busy`, `done`, `short`, and all `coin_*` outputs = 0.
  - A coin pulse in progress is truncated, and the decrement for that coin does not occur.

## Timing
- Edge 0 is the edge that samples `start`.
- Each coin costs `2 + GAP_CYCLES` cycles: SELECT, PULSE, then the gap.
- Total payout of N coins: `done` is high in the cycle after edge `N*(2+GAP_CYCLES) + 1`, and `busy` falls at the following edge.
- Zero change: state is SELECT after edge 0 and DONE after edge 1, so `done` is high in the cycle after edge 1 and no coins are ejected.
- With `GAP_CYCLES = 1`, coin k (counting from 0) pulses in the cycle after edge `3k + 1`.
- `busy` rises in the cycle after edge 0. The upstream stage must hold its next `start` until `busy` is low.

## Test plan
- **Full stock, 8 units.** After reset, `change_in = 8`, `start`, defaults → `coin_a` after edge 1, `coin_b` after edge 4, `coin_c` after edge 7, `done` after edge 10. `short = 0`, `shortfall = 0`, stocks a/b/c = 7/7/7.
- **Zero change.** `change_in = 0` → `done` after edge 1, no `coin_*` pulses, `short = 0`, stocks unchanged.
- **Exhaustion, `STOCK_MAX = 2`.**
  - First payout of 15 → coins 5, 5, 2, 2, 1; `short = 0`; stocks 0/0/1.
  - Second payout of 15 → one `coin_c` pulse, then `done` with `short = 1`, `shortfall = 14`, stocks 0/0/0.
  - Then `refill` → stocks 2/2/2.
- **Start while busy.** Pulse `start` with `change_in = 3` during a payout of 8 → ignored; exactly three coins are ejected and only one `done` occurs.
- **Refill and start together.** With stock_a = 0, assert `refill` and `start` (`change_in = 5`) in the same IDLE cycle → one `coin_a` pulse, stock_a = 7.
- **Reset mid-pulse.** Drop `rst_n` while `coin_a` is high → `coin_a` goes low immediately, `busy = 0`, and stocks return to `STOCK_MAX`. After release, IDLE with no `done` pulse.
